// File: rtl/basemul_seq.sv
// Job sequencer for one basemul_tomont unit: loads A and B from the source memories,
// runs the calculation, then drains the result pairs into the result memory.
module basemul_seq #(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             finish,
  output logic             mem_a_rd,
  output logic [DEPTH-2:0] mem_a_addr,
  input  logic [31:0]      mem_a_data,
  output logic             mem_b_rd,
  output logic [DEPTH-2:0] mem_b_addr,
  input  logic [31:0]      mem_b_data,
  output logic             set,
  output logic             readin_a,
  output logic             readin_b,
  output logic             cal_en,
  output logic             readout,
  output logic             full_in_a,
  output logic             full_in_b,
  output logic [15:0]      dina_1,
  output logic [15:0]      dina_2,
  output logic [15:0]      dinb_1,
  output logic [15:0]      dinb_2,
  output logic [DEPTH-1:0] ina_index,
  output logic [DEPTH-1:0] inb_index,
  input  logic             readin_a_ok,
  input  logic             readin_b_ok,
  input  logic             done,
  input  logic [15:0]      dout_1,
  input  logic [15:0]      dout_2,
  input  logic [DEPTH-1:0] out_index,
  input  logic             dout_valid,
  output logic             wr_en,
  output logic [DEPTH-2:0] wr_addr,
  output logic [31:0]      wr_data
);

  localparam int              NPAIR_I = 1 << (DEPTH - 1);
  localparam logic [DEPTH-1:0] NPAIR  = DEPTH'(NPAIR_I);
  localparam logic [DEPTH-1:0] LAST   = DEPTH'(NPAIR_I - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_SET, S_LOAD_A, S_END_A, S_LOAD_B, S_END_B, S_CALC, S_DRAIN, S_FIN
  } state_t;

  state_t           r_state, w_next;
  logic [DEPTH-1:0] r_ca, r_cb, r_cw;
  logic             r_rd_a, r_rd_b;
  logic [DEPTH-2:0] r_addr_a, r_addr_b;
  logic [15:0]      r_dina_1, r_dina_2, r_dinb_1, r_dinb_2;
  logic [DEPTH-1:0] r_ina_index, r_inb_index;
  logic             w_unused;

  // The result address is the pair index, so the even/odd bit of out_index is dropped.
  assign w_unused = out_index[0];

  // NOTE: every output and next-state value gets a default before the case so that
  // no path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next     = r_state;
    busy       = (r_state != S_IDLE);
    finish     = 1'b0;
    mem_a_rd   = 1'b0;
    mem_a_addr = '0;
    mem_b_rd   = 1'b0;
    mem_b_addr = '0;
    set        = 1'b0;
    readin_a   = 1'b0;
    readin_b   = 1'b0;
    cal_en     = 1'b0;
    readout    = 1'b0;
    full_in_a  = 1'b0;
    full_in_b  = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    case (r_state)
      S_IDLE: if (start) w_next = S_SET;
      S_SET: begin
        set    = 1'b1;
        w_next = S_LOAD_A;
      end
      S_LOAD_A: begin
        readin_a = 1'b1;
        if (readin_a_ok && (r_ca < NPAIR)) begin
          mem_a_rd   = 1'b1;
          mem_a_addr = r_ca[DEPTH-2:0];
          if (r_ca == LAST) w_next = S_END_A;
        end
      end
      S_END_A: begin
        readin_a  = 1'b1;
        full_in_a = 1'b1;
        w_next    = S_LOAD_B;
      end
      S_LOAD_B: begin
        readin_b = 1'b1;
        if (readin_b_ok && (r_cb < NPAIR)) begin
          mem_b_rd   = 1'b1;
          mem_b_addr = r_cb[DEPTH-2:0];
          if (r_cb == LAST) w_next = S_END_B;
        end
      end
      S_END_B: begin
        readin_b  = 1'b1;
        full_in_b = 1'b1;
        w_next    = S_CALC;
      end
      S_CALC: begin
        cal_en = 1'b1;
        if (done) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        readout = 1'b1;
        if (dout_valid) begin
          wr_en   = 1'b1;
          wr_addr = out_index[DEPTH-1:1];
          wr_data = {dout_2, dout_1};
          if (r_cw == LAST) w_next = S_FIN;
        end
      end
      S_FIN: begin
        finish = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_ca    <= '0;
      r_cb    <= '0;
      r_cw    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_FIN) begin
        r_ca <= '0;
        r_cb <= '0;
        r_cw <= '0;
      end else begin
        if (mem_a_rd) r_ca <= r_ca + DEPTH'(1);
        if (mem_b_rd) r_cb <= r_cb + DEPTH'(1);
        if (wr_en)    r_cw <= r_cw + DEPTH'(1);
      end
    end
  end

  // Source memories answer one cycle after the strobe; the flag and address follow along.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_a      <= 1'b0;
      r_rd_b      <= 1'b0;
      r_addr_a    <= '0;
      r_addr_b    <= '0;
      r_dina_1    <= '0;
      r_dina_2    <= '0;
      r_dinb_1    <= '0;
      r_dinb_2    <= '0;
      r_ina_index <= '0;
      r_inb_index <= '0;
    end else begin
      r_rd_a   <= mem_a_rd;
      r_rd_b   <= mem_b_rd;
      r_addr_a <= mem_a_addr;
      r_addr_b <= mem_b_addr;
      if (r_rd_a) begin
        r_dina_1    <= mem_a_data[15:0];
        r_dina_2    <= mem_a_data[31:16];
        r_ina_index <= {r_addr_a, 1'b0};
      end
      if (r_rd_b) begin
        r_dinb_1    <= mem_b_data[15:0];
        r_dinb_2    <= mem_b_data[31:16];
        r_inb_index <= {r_addr_b, 1'b0};
      end
    end
  end

  assign dina_1    = r_dina_1;
  assign dina_2    = r_dina_2;
  assign dinb_1    = r_dinb_1;
  assign dinb_2    = r_dinb_2;
  assign ina_index = r_ina_index;
  assign inb_index = r_inb_index;

endmodule
